// File: rtl/reg_dump_unit.sv
// Debug read-out engine: halts the datapath, walks a register index range and
// streams (index, value) words over valid/ready; one word per 2 cycles at best.
module reg_dump_unit #(
    parameter int ADDR_W       = 5,
    parameter int DATA_W       = 32,
    parameter int HALT_TIMEOUT = 255
) (
    input  logic              i_clock,
    input  logic              i_reset_n,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_first_reg,
    input  logic [ADDR_W-1:0] i_last_reg,
    input  logic              i_abort,
    output logic              o_halt_req,
    input  logic              i_halt_ack,
    output logic [ADDR_W-1:0] o_read_reg,
    input  logic [DATA_W-1:0] i_read_data,
    output logic              o_dump_valid,
    input  logic              i_dump_ready,
    output logic [ADDR_W-1:0] o_dump_index,
    output logic [DATA_W-1:0] o_dump_data,
    output logic              o_dump_last,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_error
);

    localparam int CNT_W = $clog2(HALT_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HALT_WAIT,
        S_ADDR,
        S_DATA,
        S_FINISH
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_idx;
    logic [ADDR_W-1:0] r_last;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_error;
    logic [ADDR_W-1:0] r_dump_index;
    logic [DATA_W-1:0] r_dump_data;
    logic              r_dump_last;
    logic              w_err_set;
    logic              w_start_ok;
    logic              w_timeout;
    logic              w_xfer;
    logic              w_at_last;

    assign w_start_ok = i_start && (i_first_reg <= i_last_reg);
    assign w_timeout  = (r_cnt == CNT_W'(HALT_TIMEOUT - 1));
    assign w_xfer     = o_dump_valid && i_dump_ready;
    assign w_at_last  = (r_idx == r_last);

    // Outputs decode straight from state so reset drops them without a clock.
    assign o_halt_req   = (r_state == S_HALT_WAIT) || (r_state == S_ADDR) || (r_state == S_DATA);
    assign o_dump_valid = (r_state == S_DATA);
    assign o_busy       = (r_state != S_IDLE);
    assign o_done       = (r_state == S_FINISH);
    assign o_error      = r_error;
    assign o_read_reg   = r_idx;
    assign o_dump_index = r_dump_index;
    assign o_dump_data  = r_dump_data;
    assign o_dump_last  = r_dump_last;

    always_comb begin
        w_next    = r_state;
        w_err_set = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    if (w_start_ok) w_next = S_HALT_WAIT;
                    else            w_err_set = 1'b1;
                end
            end
            S_HALT_WAIT: begin
                if (i_halt_ack) begin
                    w_next = S_ADDR;
                end else if (w_timeout) begin
                    w_next    = S_IDLE;
                    w_err_set = 1'b1;
                end
            end
            S_ADDR:   w_next = S_DATA;
            S_DATA: begin
                if (w_xfer) w_next = w_at_last ? S_FINISH : S_ADDR;
            end
            S_FINISH: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
        // Abort wins over everything, including a same-cycle handshake.
        if (i_abort && (r_state != S_IDLE)) begin
            w_next    = S_IDLE;
            w_err_set = 1'b0;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) r_state <= S_IDLE;
        else            r_state <= w_next;
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_idx        <= '0;
            r_last       <= '0;
            r_cnt        <= '0;
            r_error      <= 1'b0;
            r_dump_index <= '0;
            r_dump_data  <= '0;
            r_dump_last  <= 1'b0;
        end else begin
            r_error <= w_err_set;
            if ((r_state == S_IDLE) && w_start_ok) begin
                r_idx  <= i_first_reg;
                r_last <= i_last_reg;
                r_cnt  <= '0;
            end
            if (r_state == S_HALT_WAIT) r_cnt <= r_cnt + 1'b1;
            if (r_state == S_ADDR) begin
                r_dump_data  <= i_read_data;
                r_dump_index <= r_idx;
                r_dump_last  <= w_at_last;
            end
            if ((r_state == S_DATA) && w_xfer && !i_abort && !w_at_last)
                r_idx <= r_idx + 1'b1;
        end
    end

endmodule
